// File: rtl/mod_tick_scheduler.sv
// Sample-tick scheduler: turns each rising edge of tick_sync into a step/capture/present
// handshake sequence, counts ticks dropped while busy and flags a missing tick stream.
module mod_tick_scheduler #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MODE_W         = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick_sync,
   input  logic [MODE_W-1:0] mode_req,
   input  logic              lfsr_bit,
   output logic              lfsr_step,
   output logic [MODE_W-1:0] mode,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              sample_bit,
   output logic [MODE_W-1:0] sample_mode,
   output logic [7:0]        overrun_cnt,
   output logic              tick_lost
);

   // One-hot so lfsr_step and sample_valid come straight off state flops.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_STEP    = 4'b0010,
      ST_CAPTURE = 4'b0100,
      ST_PRESENT = 4'b1000
   } state_t;

   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic        tick_q_r;
   logic        tick_rise_s;
   logic        busy_s;
   logic [15:0] wd_cnt_r;
   logic [15:0] wd_nxt_s;

   assign tick_rise_s  = tick_sync & ~tick_q_r;
   assign busy_s       = (state_r != ST_IDLE);
   assign lfsr_step    = state_r[1];
   assign sample_valid = state_r[3];

   // Tick edge detector; resets high so a level held through reset is not a tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q_r <= 1'b1;
      end else begin
         tick_q_r <= tick_sync;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; any illegal encoding falls back to IDLE.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (tick_rise_s) begin
               state_nxt_s = ST_STEP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_STEP:    state_nxt_s = ST_CAPTURE;
         ST_CAPTURE: state_nxt_s = ST_PRESENT;
         ST_PRESENT: begin
            if (sample_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Sample and mode capture on the edge leaving CAPTURE; held otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_bit  <= 1'b0;
         sample_mode <= {MODE_W{1'b0}};
         mode        <= {MODE_W{1'b0}};
      end else if (state_r == ST_CAPTURE) begin
         sample_bit  <= lfsr_bit;
         sample_mode <= mode_req;
         mode        <= mode_req;
      end
   end

   // Saturating count of ticks that arrive while a sample is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt <= 8'd0;
      end else if (tick_rise_s && busy_s && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

   // Watchdog next value: cleared by a tick, otherwise counts up and parks at the limit.
   always_comb begin
      wd_nxt_s = wd_cnt_r;
      if (tick_rise_s) begin
         wd_nxt_s = 16'd0;
      end else if (wd_cnt_r == WD_LIMIT) begin
         wd_nxt_s = wd_cnt_r;
      end else begin
         wd_nxt_s = wd_cnt_r + 16'd1;
      end
   end

   // Watchdog counter and its flag, kept in step so tick_lost tracks counter == limit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt_r  <= 16'd0;
         tick_lost <= 1'b0;
      end else begin
         wd_cnt_r  <= wd_nxt_s;
         tick_lost <= (wd_nxt_s == WD_LIMIT);
      end
   end

endmodule

// File: tb/tb_mod_tick_scheduler.sv
// Scoreboard bench for mod_tick_scheduler: expected samples are queued at each accepted
// tick and compared when the DUT completes a valid/ready transfer.
module tb_mod_tick_scheduler;

   localparam int MODE_W = 2;
   localparam int TMO    = 16;

   typedef struct packed {
      logic              b;
      logic [MODE_W-1:0] m;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              tick_sync;
   logic [MODE_W-1:0] mode_req;
   logic              lfsr_bit;
   logic              lfsr_step;
   logic [MODE_W-1:0] mode;
   logic              sample_valid;
   logic              sample_ready;
   logic              sample_bit;
   logic [MODE_W-1:0] sample_mode;
   logic [7:0]        overrun_cnt;
   logic              tick_lost;

   exp_t sb_q[$];
   exp_t exp_r;
   int   assert_cnt = 0;
   int   fail_cnt   = 0;
   int   step_cnt   = 0;
   int   xfer_cnt   = 0;
   int   push_cnt   = 0;
   int   s0, x0, vseen;

   mod_tick_scheduler #(.TIMEOUT_CYCLES(TMO), .MODE_W(MODE_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_sync    (tick_sync),
      .mode_req     (mode_req),
      .lfsr_bit     (lfsr_bit),
      .lfsr_step    (lfsr_step),
      .mode         (mode),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_bit   (sample_bit),
      .sample_mode  (sample_mode),
      .overrun_cnt  (overrun_cnt),
      .tick_lost    (tick_lost)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic b, input logic [MODE_W-1:0] m);
      sb_q.push_back({b, m});
      push_cnt++;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_step"},  int'(lfsr_step), 0);
      check_val({tag, "_valid"}, int'(sample_valid), 0);
      check_val({tag, "_bit"},   int'(sample_bit), 0);
      check_val({tag, "_mode"},  int'(mode), 0);
      check_val({tag, "_smode"}, int'(sample_mode), 0);
      check_val({tag, "_ovr"},   int'(overrun_cnt), 0);
      check_val({tag, "_lost"},  int'(tick_lost), 0);
   endtask

   // Transfer monitor: pops the scoreboard on every completed handshake.
   always @(negedge clk) begin
      if (reset_n) begin
         if (lfsr_step) step_cnt++;
         if (sample_valid && sample_ready) begin
            xfer_cnt++;
            if (sb_q.size() == 0) begin
               check_val("sb_unexpected", 1, 0);
            end else begin
               exp_r = sb_q.pop_front();
               check_val("sb_bit",  int'(sample_bit),  int'(exp_r.b));
               check_val("sb_mode", int'(sample_mode), int'(exp_r.m));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; tick_sync = 1'b1; mode_req = 2'd0; lfsr_bit = 1'b0; sample_ready = 1'b1;
      cyc(3);
      @(negedge clk);
      check_all_zero("rst");
      cyc();
      reset_n = 1'b1;
      cyc(6);
      check_val("no_spur_step", step_cnt, 0);
      check_val("no_spur_xfer", xfer_cnt, 0);
      tick_sync = 1'b0;
      cyc(2);

      // Single tick with exact latency
      mode_req = 2'd2; lfsr_bit = 1'b1; sample_ready = 1'b1;
      tick_sync = 1'b1; push_exp(1'b1, 2'd2);
      @(negedge clk); check_val("single_n_step", int'(lfsr_step), 0);
      cyc(); tick_sync = 1'b0;
      @(negedge clk); check_val("single_n1_step", int'(lfsr_step), 1);
      check_val("single_n1_valid", int'(sample_valid), 0);
      cyc();
      @(negedge clk); check_val("single_n2_step", int'(lfsr_step), 0);
      check_val("single_n2_valid", int'(sample_valid), 0);
      check_val("single_n2_mode", int'(mode), 0);
      cyc();
      @(negedge clk); check_val("single_n3_valid", int'(sample_valid), 1);
      check_val("single_n3_bit", int'(sample_bit), 1);
      check_val("single_n3_smode", int'(sample_mode), 2);
      check_val("single_n3_mode", int'(mode), 2);
      cyc();
      @(negedge clk); check_val("single_n4_valid", int'(sample_valid), 0);
      cyc(); mode_req = 2'd1;
      cyc(5);
      @(negedge clk); check_val("mode_hold", int'(mode), 2);

      // Back-to-back ticks every 4 cycles
      cyc();
      s0 = step_cnt; x0 = xfer_cnt;
      for (int i = 0; i < 8; i++) begin
         lfsr_bit = 1'(i & 1);
         mode_req = 2'((i * 3 + 1) % 4);
         tick_sync = 1'b1;
         push_exp(lfsr_bit, mode_req);
         cyc(); tick_sync = 1'b0;
         cyc(3);
      end
      cyc(4);
      check_val("b2b_steps", step_cnt - s0, 8);
      check_val("b2b_xfers", xfer_cnt - x0, 8);
      check_val("b2b_ovr", int'(overrun_cnt), 0);

      // Backpressure with a dropped tick during the stall
      sample_ready = 1'b0; lfsr_bit = 1'b0; mode_req = 2'd3;
      tick_sync = 1'b1; push_exp(1'b0, 2'd3);
      cyc(); tick_sync = 1'b0;
      cyc(2);
      @(negedge clk); check_val("bp_valid", int'(sample_valid), 1);
      lfsr_bit = 1'b1; mode_req = 2'd1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (k == 4) tick_sync = 1'b1;
         if (k == 5) tick_sync = 1'b0;
         @(negedge clk);
         if (k % 5 == 4) begin
            check_val("bp_hold_valid", int'(sample_valid), 1);
            check_val("bp_hold_bit", int'(sample_bit), 0);
            check_val("bp_hold_smode", int'(sample_mode), 3);
         end
      end
      check_val("bp_ovr", int'(overrun_cnt), 1);
      x0 = xfer_cnt;
      cyc(); sample_ready = 1'b1;
      @(negedge clk); check_val("bp_rel_valid", int'(sample_valid), 1);
      cyc();
      @(negedge clk); check_val("bp_done_valid", int'(sample_valid), 0);
      check_val("bp_mode", int'(mode), 3);
      cyc();
      check_val("bp_one_xfer", xfer_cnt - x0, 1);

      // Watchdog flag, clear and coincident-tick corner
      lfsr_bit = 1'b0; mode_req = 2'd0;
      cyc(20);
      @(negedge clk); check_val("wd_lost_idle", int'(tick_lost), 1);
      cyc(); tick_sync = 1'b1; push_exp(1'b0, 2'd0);
      cyc(); tick_sync = 1'b0;
      @(negedge clk); check_val("wd_clear", int'(tick_lost), 0);
      cyc(13);
      @(negedge clk); check_val("wd_n14", int'(tick_lost), 0);
      cyc(2);
      @(negedge clk); check_val("wd_n16", int'(tick_lost), 1);
      cyc(10);
      @(negedge clk); check_val("wd_hold", int'(tick_lost), 1);
      cyc(); tick_sync = 1'b1; push_exp(1'b0, 2'd0);
      cyc(); tick_sync = 1'b0;
      @(negedge clk); check_val("wd_m1_clear", int'(tick_lost), 0);
      cyc(14); tick_sync = 1'b1; push_exp(1'b0, 2'd0);
      @(negedge clk); check_val("wd_m15", int'(tick_lost), 0);
      cyc(); tick_sync = 1'b0;
      @(negedge clk); check_val("wd_m16", int'(tick_lost), 0);
      cyc();
      @(negedge clk); check_val("wd_m17", int'(tick_lost), 0);

      // Reset asserted while a sample is pending
      cyc(4);
      sample_ready = 1'b0; lfsr_bit = 1'b1; mode_req = 2'd3;
      tick_sync = 1'b1;
      cyc(); tick_sync = 1'b0;
      cyc(2);
      @(negedge clk); check_val("mid_valid", int'(sample_valid), 1);
      check_val("mid_bit", int'(sample_bit), 1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("mid_rst");
      cyc(2);
      reset_n = 1'b1; sample_ready = 1'b1;
      vseen = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         @(negedge clk);
         if (sample_valid) vseen++;
      end
      check_val("mid_no_sample", vseen, 0);

      // Overrun saturation under sustained backpressure
      sample_ready = 1'b0; lfsr_bit = 1'b1; mode_req = 2'd1;
      push_exp(1'b1, 2'd1);
      for (int k = 0; k < 300; k++) begin
         tick_sync = 1'b1;
         cyc(); tick_sync = 1'b0;
         cyc();
      end
      @(negedge clk); check_val("sat_255", int'(overrun_cnt), 255);
      for (int k = 0; k < 5; k++) begin
         cyc(); tick_sync = 1'b1;
         cyc(); tick_sync = 1'b0;
      end
      @(negedge clk); check_val("sat_hold", int'(overrun_cnt), 255);
      cyc(); sample_ready = 1'b1;
      cyc(2);
      @(negedge clk); check_val("sat_drained", int'(sample_valid), 0);

      cyc(2);
      check_val("sb_empty", sb_q.size(), 0);
      check_val("sb_count", xfer_cnt, push_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
